// File: rtl/bp_nonsynth_mem_txn_checker_pkg.sv
// Shared types for the memory transaction checker: error codes, timeout FSM
// states, default widths and a tag-width helper.
package bp_nonsynth_mem_txn_checker_pkg;

  localparam int unsigned paddr_width_dflt_lp        = 40;
  localparam int unsigned block_offset_width_dflt_lp = 6;
  localparam int unsigned msg_type_width_dflt_lp     = 4;

  // Code of the first error observed since reset
  typedef enum logic [2:0] {
    e_chk_none      = 3'd0,
    e_chk_overflow  = 3'd1,
    e_chk_underflow = 3'd2,
    e_chk_mismatch  = 3'd3,
    e_chk_timeout   = 3'd4
  } bp_mem_chk_err_e;

  // Response-timeout tracker states
  typedef enum logic [1:0] {
    e_to_idle    = 2'd0,
    e_to_wait    = 2'd1,
    e_to_expired = 2'd2
  } bp_mem_chk_to_state_e;

  // Tag = {msg_type, block address}
  function automatic int unsigned tag_width(input int unsigned paddr_width,
                                            input int unsigned block_offset_width,
                                            input int unsigned msg_type_width);
    return msg_type_width + paddr_width - block_offset_width;
  endfunction

endpackage

// File: rtl/bp_nonsynth_mem_txn_checker_if.sv
// Memory command/response channel bundle as seen by the checker.
// master: the side producing the channel signals (harness / testbench).
// slave : the passive monitor, which only observes.
interface bp_nonsynth_mem_txn_checker_if
  #(parameter int unsigned paddr_width_p    = 40,
    parameter int unsigned msg_type_width_p = 4);

  logic                        cmd_v_i;
  logic                        cmd_ready_i;
  logic [msg_type_width_p-1:0] cmd_msg_type_i;
  logic [paddr_width_p-1:0]    cmd_addr_i;
  logic                        resp_v_i;
  logic                        resp_yumi_i;
  logic [msg_type_width_p-1:0] resp_msg_type_i;
  logic [paddr_width_p-1:0]    resp_addr_i;

  modport master (
    output cmd_v_i, cmd_ready_i, cmd_msg_type_i, cmd_addr_i,
    output resp_v_i, resp_yumi_i, resp_msg_type_i, resp_addr_i
  );

  modport slave (
    input cmd_v_i, cmd_ready_i, cmd_msg_type_i, cmd_addr_i,
    input resp_v_i, resp_yumi_i, resp_msg_type_i, resp_addr_i
  );

endinterface

// File: rtl/bp_nonsynth_mem_tag_fifo.sv
// In-order tag FIFO: circular buffer with wrapping read/write pointers and an
// occupancy count. Push and pop may occur together, including when full.
// Ports: clk_i, reset_n_i (async active-low), push_i/pop_i/data_i in;
//        head_c (oldest entry), full_c, empty_c (decoded from count_o),
//        count_o (registered occupancy).
module bp_nonsynth_mem_tag_fifo
  #(parameter int unsigned width_p = 38,
    parameter int unsigned els_p   = 8)
  (input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic                          push_i,
   input  logic                          pop_i,
   input  logic [width_p-1:0]            data_i,
   output logic [width_p-1:0]            head_c,
   output logic                          full_c,
   output logic                          empty_c,
   output logic [$clog2(els_p+1)-1:0]    count_o);

  localparam int unsigned ptr_width_lp   = $clog2(els_p);
  localparam int unsigned count_width_lp = $clog2(els_p+1);

  logic [width_p-1:0]      mem_q [els_p];
  logic [ptr_width_lp-1:0] rd_ptr_q;
  logic [ptr_width_lp-1:0] wr_ptr_q;

  // Storage, pointers and count; pointers wrap naturally (depth is 2^n)
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_o  <= '0;
      for (int i = 0; i < int'(els_p); i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + ptr_width_lp'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + ptr_width_lp'(1);
      case ({push_i, pop_i})
        2'b10:   count_o <= count_o + count_width_lp'(1);
        2'b01:   count_o <= count_o - count_width_lp'(1);
        default: count_o <= count_o;
      endcase
    end
  end

  assign head_c  = mem_q[rd_ptr_q];
  assign full_c  = (count_o == count_width_lp'(els_p));
  assign empty_c = (count_o == '0);

endmodule

// File: rtl/bp_nonsynth_mem_txn_checker.sv
// Passive checker for an in-order memory command/response channel pair.
// Records each accepted command's tag, checks responses against the oldest
// outstanding tag, enforces a response timeout and keeps sticky error flags.
// Ports: clk_i, reset_n_i (async active-low); mem (slave view of channels);
//        outstanding_o, cmd_count_o, resp_count_o statistics;
//        err_*_o sticky flags, error_o (OR of flags), first_err_code_o.
module bp_nonsynth_mem_txn_checker
  import bp_nonsynth_mem_txn_checker_pkg::*;
  #(parameter int unsigned paddr_width_p        = 40,
    parameter int unsigned block_offset_width_p = 6,
    parameter int unsigned msg_type_width_p     = 4,
    parameter int unsigned max_outstanding_p    = 8,
    parameter int unsigned timeout_cycles_p     = 4096)
  (input  logic                                   clk_i,
   input  logic                                   reset_n_i,
   bp_nonsynth_mem_txn_checker_if.slave           mem,
   output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
   output logic [31:0]                            cmd_count_o,
   output logic [31:0]                            resp_count_o,
   output logic                                   err_overflow_o,
   output logic                                   err_underflow_o,
   output logic                                   err_mismatch_o,
   output logic                                   err_timeout_o,
   output logic                                   error_o,
   output logic [2:0]                             first_err_code_o);

  localparam int unsigned tag_width_lp =
    tag_width(paddr_width_p, block_offset_width_p, msg_type_width_p);
  localparam int unsigned cnt_width_lp = $clog2(max_outstanding_p+1);
  localparam int unsigned to_width_lp  = $clog2(timeout_cycles_p);

  logic                    cmd_fire, resp_fire;
  logic [tag_width_lp-1:0] cmd_tag, resp_tag, head_tag;
  logic                    fifo_full, fifo_empty, push, pop;
  logic                    underflow_ev, mismatch_ev, overflow_ev, timeout_ev;
  logic                    drain;
  logic [to_width_lp-1:0]  to_cnt_q;
  bp_mem_chk_to_state_e    state_q, state_n;
  bp_mem_chk_err_e         first_err_q;
  logic                    unused_offset_bits;

  assign cmd_fire  = mem.cmd_v_i & mem.cmd_ready_i;
  assign resp_fire = mem.resp_v_i & mem.resp_yumi_i;
  assign cmd_tag   = {mem.cmd_msg_type_i,  mem.cmd_addr_i[paddr_width_p-1:block_offset_width_p]};
  assign resp_tag  = {mem.resp_msg_type_i, mem.resp_addr_i[paddr_width_p-1:block_offset_width_p]};
  assign unused_offset_bits = ^{mem.cmd_addr_i[block_offset_width_p-1:0],
                                mem.resp_addr_i[block_offset_width_p-1:0]};

  // A response always pops when something is outstanding; a full FIFO only
  // accepts a command if that pop frees the slot on the same edge.
  assign pop  = resp_fire & ~fifo_empty;
  assign push = cmd_fire & (~fifo_full | pop);

  bp_nonsynth_mem_tag_fifo #(
    .width_p (tag_width_lp),
    .els_p   (max_outstanding_p)
  ) tag_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (push),
    .pop_i     (pop),
    .data_i    (cmd_tag),
    .head_c    (head_tag),
    .full_c    (fifo_full),
    .empty_c   (fifo_empty),
    .count_o   (outstanding_o)
  );

  assign underflow_ev = resp_fire & fifo_empty;
  assign mismatch_ev  = pop & (head_tag != resp_tag);
  assign overflow_ev  = cmd_fire & fifo_full & ~resp_fire;
  assign drain        = pop & ~push & (outstanding_o == cnt_width_lp'(1));

  // Timeout FSM state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= e_to_idle;
    else            state_q <= state_n;
  end

  // Timeout FSM next state; expiry only reported from WAIT
  always_comb begin
    state_n    = state_q;
    timeout_ev = 1'b0;
    case (state_q)
      e_to_idle: begin
        if (push) state_n = e_to_wait;
      end
      e_to_wait: begin
        timeout_ev = ~resp_fire & (to_cnt_q == to_width_lp'(timeout_cycles_p - 1));
        if (drain)           state_n = e_to_idle;
        else if (timeout_ev) state_n = e_to_expired;
      end
      e_to_expired: begin
        if (drain)          state_n = e_to_idle;
        else if (resp_fire) state_n = e_to_wait;
      end
      default: state_n = e_to_idle;
    endcase
  end

  // Cycles with work outstanding and no response; saturates at the limit
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                                          to_cnt_q <= '0;
    else if ((outstanding_o == '0) || resp_fire)             to_cnt_q <= '0;
    else if (to_cnt_q != to_width_lp'(timeout_cycles_p - 1)) to_cnt_q <= to_cnt_q + to_width_lp'(1);
  end

  // Statistics, sticky flags and first-error capture
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cmd_count_o     <= '0;
      resp_count_o    <= '0;
      err_overflow_o  <= 1'b0;
      err_underflow_o <= 1'b0;
      err_mismatch_o  <= 1'b0;
      err_timeout_o   <= 1'b0;
      error_o         <= 1'b0;
      first_err_q     <= e_chk_none;
    end else begin
      if (cmd_fire)  cmd_count_o  <= cmd_count_o + 32'd1;
      if (resp_fire) resp_count_o <= resp_count_o + 32'd1;
      err_overflow_o  <= err_overflow_o  | overflow_ev;
      err_underflow_o <= err_underflow_o | underflow_ev;
      err_mismatch_o  <= err_mismatch_o  | mismatch_ev;
      err_timeout_o   <= err_timeout_o   | timeout_ev;
      error_o         <= error_o | overflow_ev | underflow_ev | mismatch_ev | timeout_ev;
      if (first_err_q == e_chk_none) begin
        if      (underflow_ev) first_err_q <= e_chk_underflow;
        else if (mismatch_ev)  first_err_q <= e_chk_mismatch;
        else if (overflow_ev)  first_err_q <= e_chk_overflow;
        else if (timeout_ev)   first_err_q <= e_chk_timeout;
      end
    end
  end

  assign first_err_code_o = first_err_q;

endmodule

// File: tb/tb_bp_nonsynth_mem_txn_checker.sv
// Directed scenarios plus randomized traffic against a queue-based model of
// the in-order memory channel rules.
module tb_bp_nonsynth_mem_txn_checker;

  localparam int unsigned PW = 40;
  localparam int unsigned OW = 6;
  localparam int unsigned MW = 4;
  localparam int unsigned MO = 8;
  localparam int unsigned TO = 16;
  localparam int unsigned TW = MW + PW - OW;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  outstanding;
  logic [31:0] cmd_count, resp_count;
  logic        err_overflow, err_underflow, err_mismatch, err_timeout, error;
  logic [2:0]  first_err_code;

  bp_nonsynth_mem_txn_checker_if #(.paddr_width_p(PW), .msg_type_width_p(MW)) mem_if ();

  bp_nonsynth_mem_txn_checker #(
    .paddr_width_p        (PW),
    .block_offset_width_p (OW),
    .msg_type_width_p     (MW),
    .max_outstanding_p    (MO),
    .timeout_cycles_p     (TO)
  ) dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .mem              (mem_if),
    .outstanding_o    (outstanding),
    .cmd_count_o      (cmd_count),
    .resp_count_o     (resp_count),
    .err_overflow_o   (err_overflow),
    .err_underflow_o  (err_underflow),
    .err_mismatch_o   (err_mismatch),
    .err_timeout_o    (err_timeout),
    .error_o          (error),
    .first_err_code_o (first_err_code)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [TW-1:0] m_q[$];
  logic [31:0]   m_cmd_cnt, m_resp_cnt;
  logic          m_ovf, m_und, m_mis, m_to;
  logic [2:0]    m_code;
  int            m_idle;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  function automatic logic [TW-1:0] mk_tag(input logic [MW-1:0] t, input logic [PW-1:0] a);
    return {t, a[PW-1:OW]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".outstanding"}, 64'(outstanding),    64'(m_q.size()));
    chk({tag, ".cmd_count"},   64'(cmd_count),      64'(m_cmd_cnt));
    chk({tag, ".resp_count"},  64'(resp_count),     64'(m_resp_cnt));
    chk({tag, ".overflow"},    64'(err_overflow),   64'(m_ovf));
    chk({tag, ".underflow"},   64'(err_underflow),  64'(m_und));
    chk({tag, ".mismatch"},    64'(err_mismatch),   64'(m_mis));
    chk({tag, ".timeout"},     64'(err_timeout),    64'(m_to));
    chk({tag, ".error"},       64'(error),          64'(m_ovf | m_und | m_mis | m_to));
    chk({tag, ".first_code"},  64'(first_err_code), 64'(m_code));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cmd_cnt  = '0;
    m_resp_cnt = '0;
    {m_ovf, m_und, m_mis, m_to} = 4'b0;
    m_code = 3'd0;
    m_idle = 0;
  endtask

  // Apply one clock edge's worth of channel activity to the model
  task automatic model_step(input bit cf, input bit rf,
                            input logic [TW-1:0] ctag, input logic [TW-1:0] rtag);
    bit und = 0, mis = 0, ovf = 0, tmo = 0;
    bit was_full = (m_q.size() == int'(MO));
    logic [TW-1:0] head;
    // timeout: TO consecutive cycles with work pending and no response
    if (m_q.size() == 0 || rf) m_idle = 0;
    else if (m_idle == int'(TO) - 1) tmo = 1;
    else m_idle++;
    if (rf) begin
      if (m_q.size() == 0) und = 1;
      else begin
        head = m_q.pop_front();
        if (head != rtag) mis = 1;
      end
    end
    if (cf) begin
      if (was_full && !rf) ovf = 1;
      else m_q.push_back(ctag);
    end
    if (cf) m_cmd_cnt  = m_cmd_cnt + 32'd1;
    if (rf) m_resp_cnt = m_resp_cnt + 32'd1;
    m_ovf |= ovf; m_und |= und; m_mis |= mis; m_to |= tmo;
    if (m_code == 3'd0) begin
      if (und)      m_code = 3'd2;
      else if (mis) m_code = 3'd3;
      else if (ovf) m_code = 3'd1;
      else if (tmo) m_code = 3'd4;
    end
  endtask

  // Called at a negedge: drive, advance one clock, check at the next negedge
  task automatic cycle(input string tag,
                       input bit cv, input bit cr, input logic [MW-1:0] ct, input logic [PW-1:0] ca,
                       input bit rv, input bit ry, input logic [MW-1:0] rt, input logic [PW-1:0] ra);
    mem_if.cmd_v_i         = cv;
    mem_if.cmd_ready_i     = cr;
    mem_if.cmd_msg_type_i  = ct;
    mem_if.cmd_addr_i      = ca;
    mem_if.resp_v_i        = rv;
    mem_if.resp_yumi_i     = ry;
    mem_if.resp_msg_type_i = rt;
    mem_if.resp_addr_i     = ra;
    model_step(cv & cr, rv & ry, mk_tag(ct, ca), mk_tag(rt, ra));
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic cmd(input string tag, input logic [PW-1:0] a);
    cycle(tag, 1, 1, 4'd0, a, 0, 0, 4'd0, '0);
  endtask

  task automatic resp(input string tag, input logic [PW-1:0] a);
    cycle(tag, 0, 0, 4'd0, '0, 1, 1, 4'd0, a);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 0, 0, 4'd0, '0, 0, 0, 4'd0, '0);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    mem_if.cmd_v_i  = 1'b0;
    mem_if.resp_v_i = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  localparam logic [PW-1:0] A40  = 40'h80_0000_0040;
  localparam logic [PW-1:0] A80  = 40'h80_0000_0080;
  localparam logic [PW-1:0] A100 = 40'h80_0000_0100;

  initial begin
    int pr[4];
    reset_n = 1'b0;
    mem_if.cmd_v_i = 0; mem_if.cmd_ready_i = 0; mem_if.cmd_msg_type_i = '0; mem_if.cmd_addr_i = '0;
    mem_if.resp_v_i = 0; mem_if.resp_yumi_i = 0; mem_if.resp_msg_type_i = '0; mem_if.resp_addr_i = '0;
    model_reset();
    @(negedge clk);
    do_reset("init");

    // 1: two reads, in-order matching responses
    cmd("t1c0", A40);  chk("t1.out_a", 64'(outstanding), 64'd1);
    cmd("t1c1", A80);  chk("t1.out_b", 64'(outstanding), 64'd2);
    resp("t1r0", A40 + 40'h3f); chk("t1.out_c", 64'(outstanding), 64'd1);
    resp("t1r1", A80); chk("t1.out_d", 64'(outstanding), 64'd0);
    chk("t1.cmd_count", 64'(cmd_count), 64'd2);
    chk("t1.resp_count", 64'(resp_count), 64'd2);
    chk("t1.error", 64'(error), 64'd0);

    // 2: wrong block address in response
    do_reset("t2rst");
    cmd("t2c", A40);
    resp("t2r", A100);
    chk("t2.mismatch", 64'(err_mismatch), 64'd1);
    chk("t2.code", 64'(first_err_code), 64'd3);
    chk("t2.out", 64'(outstanding), 64'd0);

    // 3: response with nothing outstanding, concurrent command still pushed
    do_reset("t3rst");
    cycle("t3", 1, 1, 4'd0, A40, 1, 1, 4'd0, A80);
    chk("t3.underflow", 64'(err_underflow), 64'd1);
    chk("t3.code", 64'(first_err_code), 64'd2);
    chk("t3.out", 64'(outstanding), 64'd1);

    // 4: fill, overflow alone, then full + concurrent response is legal
    do_reset("t4rst");
    for (int i = 0; i < int'(MO); i++) cmd("t4fill", A40 + 40'(i * 64));
    cmd("t4ovf", A100);
    chk("t4.overflow", 64'(err_overflow), 64'd1);
    chk("t4.code", 64'(first_err_code), 64'd1);
    chk("t4.out_a", 64'(outstanding), 64'd8);
    cycle("t4both", 1, 1, 4'd0, A100, 1, 1, 4'd0, A40);
    chk("t4.out_b", 64'(outstanding), 64'd8);
    chk("t4.mismatch", 64'(err_mismatch), 64'd0);
    chk("t4.underflow", 64'(err_underflow), 64'd0);

    // 5: timeout exactly TO cycles after the push
    do_reset("t5rst");
    cmd("t5c", A40);
    for (int i = 0; i < int'(TO) - 1; i++) idle("t5wait");
    chk("t5.not_yet", 64'(err_timeout), 64'd0);
    idle("t5exp");
    chk("t5.timeout", 64'(err_timeout), 64'd1);
    chk("t5.code", 64'(first_err_code), 64'd4);
    idle("t5hold");
    resp("t5r", A40);
    chk("t5.out", 64'(outstanding), 64'd0);
    chk("t5.sticky", 64'(err_timeout), 64'd1);

    // 6: asynchronous reset mid-flight
    do_reset("t6rst");
    cycle("t6u", 1, 1, 4'd0, A40, 1, 1, 4'd0, A40);
    cmd("t6c1", A80);
    cmd("t6c2", A100);
    chk("t6.out3", 64'(outstanding), 64'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6.async_out", 64'(outstanding), 64'd0);
    chk("t6.async_err", 64'(error), 64'd0);
    chk("t6.async_und", 64'(err_underflow), 64'd0);
    chk("t6.async_cmd", 64'(cmd_count), 64'd0);
    chk("t6.async_code", 64'(first_err_code), 64'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cmd("t6c", A80);
    resp("t6r", A80);
    chk("t6.clean", 64'(error), 64'd0);

    // Randomized traffic, varying response pressure per segment
    pr[0] = 0; pr[1] = 25; pr[2] = 60; pr[3] = 90;
    for (int seg = 0; seg < 8; seg++) begin
      do_reset("rnd_rst");
      for (int i = 0; i < 60; i++) begin
        bit cv, cr, rv, ry;
        logic [MW-1:0] ct, rt;
        logic [PW-1:0] ca, ra;
        cv = ($urandom_range(0, 99) < 50);
        cr = ($urandom_range(0, 99) < 80);
        ct = MW'($urandom_range(0, 3));
        ca = {8'h80, 26'($urandom), 6'($urandom)};
        rv = ($urandom_range(0, 99) < pr[seg % 4]);
        ry = ($urandom_range(0, 99) < 85);
        if (m_q.size() > 0 && $urandom_range(0, 9) < 8) begin
          rt = m_q[0][TW-1 -: MW];
          ra = {m_q[0][TW-MW-1:0], 6'($urandom)};
        end else begin
          rt = MW'($urandom_range(0, 3));
          ra = {8'h80, 26'($urandom), 6'($urandom)};
        end
        cycle("rnd", cv, cr, ct, ca, rv, ry, rt, ra);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
